sort_pkt_ctrl: RTL

- Packet-level controller that sequences the bubble-sort datapath.
- Captures one Avalon-ST packet of unsigned words into a local buffer, then runs compare-swap passes over the buffer one adjacent pair per cycle.
- Streams the sorted packet out, ascending, on an Avalon-ST source.
- Processes one packet at a time. The sink is stalled from the end of capture until the sorted packet has been fully sent.

---
 rtl/sort_pkt_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sort_pkt_ctrl.sv
// Packet bubble-sort controller: captures one Avalon-ST packet into a local
// buffer, sorts it ascending with one compare-swap per cycle, then streams it out.
module sort_pkt_ctrl #(
  parameter int DWIDTH      = 10,
  parameter int MAX_PKT_LEN = 10,
  parameter int CTR_SZ      = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, RECV, SORT, SEND} state_t;

  localparam logic [CTR_SZ-1:0] MAX_LEN = CTR_SZ'(MAX_PKT_LEN);
  localparam logic [CTR_SZ-1:0] ONE     = CTR_SZ'(1);
  localparam logic [CTR_SZ-1:0] TWO     = CTR_SZ'(2);

  state_t            state;
  logic [DWIDTH-1:0] mem [MAX_PKT_LEN];
  logic [CTR_SZ-1:0] len, pass_idx, pair_idx, out_idx;
  logic              swapped;

  logic              snk_xfer, src_xfer;
  logic [CTR_SZ-1:0] pair_nxt, out_nxt, last_pair;
  logic [DWIDTH-1:0] lo_w, hi_w;
  logic              do_swap, pass_end, sort_done;

  assign snk_xfer  = snk_valid_i & snk_ready_o;
  assign src_xfer  = src_valid_o & src_ready_i;
  assign pair_nxt  = pair_idx + ONE;
  assign out_nxt   = out_idx + ONE;
  assign last_pair = len - TWO - pass_idx;
  assign lo_w      = mem[pair_idx];
  assign hi_w      = mem[pair_nxt];
  assign do_swap   = (len != ONE) && (lo_w > hi_w);
  assign pass_end  = (pair_idx == last_pair);
  // early exit on a clean pass; a swap in the current cycle still counts
  assign sort_done = (len == ONE) ||
                     (pass_end && (!(swapped || do_swap) || pass_idx == len - TWO));

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state               <= IDLE;
      len                 <= '0;
      pass_idx            <= '0;
      pair_idx            <= '0;
      out_idx             <= '0;
      swapped             <= 1'b0;
      snk_ready_o         <= 1'b1;
      src_valid_o         <= 1'b0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_data_o          <= '0;
      busy_o              <= 1'b0;
    end else begin
      case (state)
        IDLE: if (snk_xfer && snk_startofpacket_i) begin
          mem[0] <= snk_data_i;
          len    <= ONE;
          if (snk_endofpacket_i) begin
            state       <= SORT;
            snk_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            pass_idx    <= '0;
            pair_idx    <= '0;
            swapped     <= 1'b0;
          end else begin
            state <= RECV;
          end
        end
        RECV: if (snk_xfer) begin
          if (snk_startofpacket_i) begin
            mem[0] <= snk_data_i;
            len    <= ONE;
          end else if (len < MAX_LEN) begin
            mem[len] <= snk_data_i;
            len      <= len + ONE;
          end
          if (snk_endofpacket_i) begin
            state       <= SORT;
            snk_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            pass_idx    <= '0;
            pair_idx    <= '0;
            swapped     <= 1'b0;
          end
        end
        SORT: begin
          if (do_swap) begin
            mem[pair_idx] <= hi_w;
            mem[pair_nxt] <= lo_w;
          end
          if (sort_done) begin
            state               <= SEND;
            out_idx             <= '0;
            src_valid_o         <= 1'b1;
            src_startofpacket_o <= 1'b1;
            src_endofpacket_o   <= (len == ONE);
            // buf[0] may be swapped in this same cycle
            src_data_o          <= (pair_idx == '0 && do_swap) ? hi_w : mem[0];
          end else if (pass_end) begin
            pass_idx <= pass_idx + ONE;
            pair_idx <= '0;
            swapped  <= 1'b0;
          end else begin
            pair_idx <= pair_nxt;
            swapped  <= swapped | do_swap;
          end
        end
        SEND: if (src_xfer) begin
          if (src_endofpacket_o) begin
            state               <= IDLE;
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            busy_o              <= 1'b0;
            snk_ready_o         <= 1'b1;
          end else begin
            out_idx             <= out_nxt;
            src_data_o          <= mem[out_nxt];
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= (out_nxt == len - ONE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
